// File: rtl/echo_msg_serializer.sv
// echo_msg_serializer
// Takes one packed 192-bit echo indication per enqueue and streams it onto a
// 32-bit portal link: a header beat, then only the payload words that belong
// to the message tag. Unknown tags produce no beats and are counted as drops.
// A new message can be accepted on the cycle its predecessor's last beat
// transfers, so consecutive messages stream with no idle cycle between them.
module echo_msg_serializer #(
    parameter logic [7:0] PORTAL_ID = 8'd5,
    parameter int         MSG_WIDTH = 192
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 pipe_enq__ENA,
    input  logic [MSG_WIDTH-1:0] pipe_enq_v,
    output logic                 pipe_enq__RDY,
    output logic                 out_beat__ENA,
    output logic [31:0]          out_beat_data,
    output logic                 out_beat_last,
    input  logic                 out_beat__RDY,
    output logic [15:0]          drop_count,
    output logic [15:0]          msg_count
);

    localparam logic [31:0] TAG_SAY  = 32'd1;
    localparam logic [31:0] TAG_SAY2 = 32'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Select 32-bit word k of a packed message; out-of-range indices read 0.
    function automatic logic [31:0] get_word(input logic [MSG_WIDTH-1:0] msg,
                                             input logic [2:0] k);
        logic [31:0] w;
        case (k)
            3'd0:    w = msg[31:0];
            3'd1:    w = msg[63:32];
            3'd2:    w = msg[95:64];
            3'd3:    w = msg[127:96];
            3'd4:    w = msg[159:128];
            3'd5:    w = msg[191:160];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t                 state_q,      state_d;
    logic [MSG_WIDTH-1:0]   msg_q,        msg_d;
    logic [2:0]             idx_q,        idx_d;
    logic [2:0]             nbeats_q,     nbeats_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic [15:0]            msg_count_q,  msg_count_d;

    logic [31:0] in_tag_s;
    logic        in_tag_ok_s;
    logic [2:0]  in_len_s;
    logic        last_s;
    logic        xfer_s;
    logic        enq_rdy_s;
    logic        accept_s;
    logic [2:0]  word_sel_s;
    logic [31:0] beat_data_s;

    // Decode the offered message tag and the handshake conditions.
    always_comb begin
        in_tag_s    = pipe_enq_v[31:0];
        in_tag_ok_s = (in_tag_s == TAG_SAY) || (in_tag_s == TAG_SAY2);
        if (in_tag_s == TAG_SAY2) begin
            in_len_s = 3'd3;
        end else begin
            in_len_s = 3'd2;
        end
        last_s    = (state_q == ST_SEND) && (idx_q == nbeats_q);
        xfer_s    = (state_q == ST_SEND) && out_beat__RDY;
        // Ready while idle, or while the last beat leaves so the next
        // message can follow without a bubble.
        enq_rdy_s = (state_q == ST_IDLE) || (xfer_s && last_s);
        accept_s  = pipe_enq__ENA && enq_rdy_s;
    end

    // Build the current beat: header at index 0, then the tag's payload words.
    always_comb begin
        beat_data_s = 32'h0000_0000;
        // say payload starts at word 1, say2 payload starts at word 3.
        if (msg_q[31:0] == TAG_SAY2) begin
            word_sel_s = idx_q + 3'd2;
        end else begin
            word_sel_s = idx_q;
        end
        if (state_q == ST_SEND) begin
            if (idx_q == 3'd0) begin
                beat_data_s = {PORTAL_ID, 5'd0, nbeats_q, msg_q[15:0]};
            end else begin
                beat_data_s = get_word(msg_q, word_sel_s);
            end
        end else begin
            beat_data_s = 32'h0000_0000;
        end
    end

    // Next-state: advance or finish the current message, then take a new one.
    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        idx_d        = idx_q;
        nbeats_d     = nbeats_q;
        drop_count_d = drop_count_q;
        msg_count_d  = msg_count_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = idx_q;
            end
            ST_SEND: begin
                if (xfer_s) begin
                    if (last_s) begin
                        msg_count_d = msg_count_q + 16'd1;
                        state_d     = ST_IDLE;
                        idx_d       = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase

        if (accept_s) begin
            if (in_tag_ok_s) begin
                msg_d    = pipe_enq_v;
                idx_d    = 3'd0;
                nbeats_d = in_len_s;
                state_d  = ST_SEND;
            end else begin
                state_d = ST_IDLE;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end else begin
                    drop_count_d = drop_count_q;
                end
            end
        end else begin
            msg_d = msg_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            msg_q        <= '0;
            idx_q        <= 3'd0;
            nbeats_q     <= 3'd0;
            drop_count_q <= 16'd0;
            msg_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            idx_q        <= idx_d;
            nbeats_q     <= nbeats_d;
            drop_count_q <= drop_count_d;
            msg_count_q  <= msg_count_d;
        end
    end

    assign pipe_enq__RDY = enq_rdy_s;
    assign out_beat__ENA = (state_q == ST_SEND);
    assign out_beat_data = beat_data_s;
    assign out_beat_last = last_s;
    assign drop_count    = drop_count_q;
    assign msg_count     = msg_count_q;

endmodule

// File: tb/tb_echo_msg_serializer.sv
// Self-checking bench for echo_msg_serializer: a cycle-by-cycle vector table
// plus a hand-written mid-message reset sequence.
module tb_echo_msg_serializer;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         enq_ena = 1'b0;
    logic [191:0] enq_v = '0;
    logic         enq_rdy;
    logic         beat_ena;
    logic [31:0]  beat_data;
    logic         beat_last;
    logic         beat_rdy = 1'b0;
    logic [15:0]  drop_count;
    logic [15:0]  msg_count;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    echo_msg_serializer #(.PORTAL_ID(8'd5), .MSG_WIDTH(192)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pipe_enq__ENA (enq_ena),
        .pipe_enq_v    (enq_v),
        .pipe_enq__RDY (enq_rdy),
        .out_beat__ENA (beat_ena),
        .out_beat_data (beat_data),
        .out_beat_last (beat_last),
        .out_beat__RDY (beat_rdy),
        .drop_count    (drop_count),
        .msg_count     (msg_count)
    );

    typedef struct {
        logic         ena;
        logic [191:0] msg;
        logic         brdy;
        logic         e_rdy;
        logic         e_ena;
        logic [31:0]  e_data;
        logic         e_last;
        logic [15:0]  e_drop;
        logic [15:0]  e_mc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [191:0] mk(input logic [31:0] tag, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3,
                                        input logic [31:0] w4, input logic [31:0] w5);
        return {w5, w4, w3, w2, w1, tag};
    endfunction

    task automatic add(input logic ena, input logic [191:0] msg, input logic brdy,
                       input logic e_rdy, input logic e_ena, input logic [31:0] e_data,
                       input logic e_last, input logic [15:0] e_drop, input logic [15:0] e_mc);
        vec_t v;
        v.ena = ena; v.msg = msg; v.brdy = brdy;
        v.e_rdy = e_rdy; v.e_ena = e_ena; v.e_data = e_data; v.e_last = e_last;
        v.e_drop = e_drop; v.e_mc = e_mc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic chk_all(input int step, input logic e_rdy, input logic e_ena,
                           input logic [31:0] e_data, input logic e_last,
                           input logic [15:0] e_drop, input logic [15:0] e_mc);
        chk("enq_rdy",    step, {31'd0, enq_rdy},   {31'd0, e_rdy});
        chk("beat_ena",   step, {31'd0, beat_ena},  {31'd0, e_ena});
        chk("beat_data",  step, beat_data,          e_data);
        chk("beat_last",  step, {31'd0, beat_last}, {31'd0, e_last});
        chk("drop_count", step, {16'd0, drop_count}, {16'd0, e_drop});
        chk("msg_count",  step, {16'd0, msg_count},  {16'd0, e_mc});
    endtask

    initial begin
        logic [191:0] m_say, m_say2, m_bp, m_b2b, m_bad7, m_badhi, m_s5, m_junk;
        logic [191:0] m_r2, m_r1;
        logic         found;

        m_say   = mk(32'd1, 32'hA, 32'hB, 32'h0, 32'h0, 32'h0);
        m_say2  = mk(32'd2, 32'hDEAD, 32'hBEEF, 32'h11, 32'h22, 32'h33);
        m_bp    = mk(32'd1, 32'hC1, 32'hC2, 32'h99, 32'h98, 32'h97);
        m_b2b   = mk(32'd2, 32'h77, 32'h78, 32'h31, 32'h32, 32'h33);
        m_bad7  = mk(32'd7, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
        m_badhi = mk(32'h0001_0001, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
        m_s5    = mk(32'd1, 32'h51, 32'h52, 32'h0, 32'h0, 32'h0);
        m_junk  = mk(32'd2, 32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5);
        m_r2    = mk(32'd2, 32'h0, 32'h0, 32'h61, 32'h62, 32'h63);
        m_r1    = mk(32'd1, 32'h71, 32'h72, 32'h0, 32'h0, 32'h0);

        //   ena   msg      brdy rdy  ena  data           last drop   mc
        add(1'b0, '0,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0, 16'd0);
        // say, sink always ready
        add(1'b1, m_say,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0, 16'd0);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h05020001, 1'b0, 16'd0, 16'd0);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'hA,        1'b0, 16'd0, 16'd0);
        add(1'b0, '0,      1'b1, 1'b1, 1'b1, 32'hB,        1'b1, 16'd0, 16'd0);
        add(1'b0, '0,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0, 16'd1);
        // say2: words 1,2 must never appear
        add(1'b1, m_say2,  1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0, 16'd1);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h05030002, 1'b0, 16'd0, 16'd1);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h11,       1'b0, 16'd0, 16'd1);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h22,       1'b0, 16'd0, 16'd1);
        add(1'b0, '0,      1'b1, 1'b1, 1'b1, 32'h33,       1'b1, 16'd0, 16'd1);
        add(1'b0, '0,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0, 16'd2);
        // backpressure on beat 1; enqueue offered during stall is ignored
        add(1'b1, m_bp,    1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0, 16'd2);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h05020001, 1'b0, 16'd0, 16'd2);
        add(1'b0, '0,      1'b0, 1'b0, 1'b1, 32'hC1,       1'b0, 16'd0, 16'd2);
        add(1'b1, m_bad7,  1'b0, 1'b0, 1'b1, 32'hC1,       1'b0, 16'd0, 16'd2);
        add(1'b0, '0,      1'b0, 1'b0, 1'b1, 32'hC1,       1'b0, 16'd0, 16'd2);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'hC1,       1'b0, 16'd0, 16'd2);
        // back-to-back: say2 accepted on the last beat of the previous message
        add(1'b1, m_b2b,   1'b1, 1'b1, 1'b1, 32'hC2,       1'b1, 16'd0, 16'd2);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h05030002, 1'b0, 16'd0, 16'd3);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h31,       1'b0, 16'd0, 16'd3);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h32,       1'b0, 16'd0, 16'd3);
        // bad tag 0x10001 offered on the last-beat handoff
        add(1'b1, m_badhi, 1'b1, 1'b1, 1'b1, 32'h33,       1'b1, 16'd0, 16'd3);
        // bad tag 7 while idle
        add(1'b1, m_bad7,  1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd1, 16'd4);
        add(1'b0, '0,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd2, 16'd4);
        // last beat stalled: no handoff while the sink is not ready
        add(1'b1, m_s5,    1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd2, 16'd4);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h05020001, 1'b0, 16'd2, 16'd4);
        add(1'b0, '0,      1'b1, 1'b0, 1'b1, 32'h51,       1'b0, 16'd2, 16'd4);
        add(1'b1, m_junk,  1'b0, 1'b0, 1'b1, 32'h52,       1'b1, 16'd2, 16'd4);
        add(1'b0, '0,      1'b1, 1'b1, 1'b1, 32'h52,       1'b1, 16'd2, 16'd4);
        add(1'b0, '0,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd2, 16'd5);

        // Initial reset
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            enq_ena  = vecs[i].ena;
            enq_v    = vecs[i].msg;
            beat_rdy = vecs[i].brdy;
            #1;
            chk_all(i, vecs[i].e_rdy, vecs[i].e_ena, vecs[i].e_data, vecs[i].e_last,
                    vecs[i].e_drop, vecs[i].e_mc);
        end

        // Reset in the middle of a say2 message, on beat 2
        @(negedge CLK);
        enq_ena = 1'b1; enq_v = m_r2; beat_rdy = 1'b1;
        @(negedge CLK);
        enq_ena = 1'b0; enq_v = '0;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            #1;
            if (beat_ena && beat_data == 32'h62) begin
                found = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        chk("reach_beat2", 900, {31'd0, found}, 32'd1);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk_all(901, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);
        @(negedge CLK);
        #1;
        chk_all(902, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);

        // Normal say after reset
        enq_ena = 1'b1; enq_v = m_r1;
        @(negedge CLK);
        enq_ena = 1'b0; enq_v = '0;
        #1;
        chk_all(903, 1'b0, 1'b1, 32'h05020001, 1'b0, 16'd0, 16'd0);
        @(negedge CLK);
        #1;
        chk_all(904, 1'b0, 1'b1, 32'h71, 1'b0, 16'd0, 16'd0);
        @(negedge CLK);
        #1;
        chk_all(905, 1'b1, 1'b1, 32'h72, 1'b1, 16'd0, 16'd0);
        @(negedge CLK);
        #1;
        chk_all(906, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
